sync_pkt_fifo_tx: RTL and testbench



---
 rtl/sync_pkt_fifo_tx.sv | 130 +++++++++++++
 tb/tb_sync_pkt_fifo_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pkt_fifo_tx.sv
`default_nettype none
// ============================================================================
// sync_pkt_fifo_tx : single-clock packet FIFO with write commit/discard and
//                    read commit/rewind. Optional macro SYNC_PKT_FIFO_OVF_DROP_EN.
// Revision 1.0
// ============================================================================
module sync_pkt_fifo_tx #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 9,
  parameter int AF_LEVEL = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_commit,
  input  logic             wr_discard,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_commit,
  input  logic             rd_rewind,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic [ASIZE:0]   wr_free,
`ifdef SYNC_PKT_FIFO_OVF_DROP_EN
  output logic [ASIZE:0]   rd_avail,
  output logic             ovf_drop
`else
  output logic [ASIZE:0]   rd_avail
`endif
);

  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_W = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_W    = (ASIZE+1)'(AF_LEVEL);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wp, cwp, rp, crp;
  logic [ASIZE:0] used, wp_inc, rp_inc;
  logic           wr_acc, rd_acc, wr_drop, wr_pub;

  // Space is counted against the committed read pointer, so words read but
  // not yet released stay reserved for a possible retransmission.
  assign used        = wp - crp;
  assign full        = (used == DEPTH_W);
  assign empty       = (rp == cwp);
  assign almost_full = (wr_free < AF_W);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty & ~rd_rewind;
  assign wp_inc = wp + {{ASIZE{1'b0}}, wr_acc};
  assign rp_inc = rp + {{ASIZE{1'b0}}, rd_acc};

`ifdef SYNC_PKT_FIFO_OVF_DROP_EN
  logic ovf_err, ovf_hit;

  // A commit after (or together with) an overflowing write drops the packet.
  assign ovf_hit = wr_commit & ~wr_discard & (ovf_err | (wr_en & full));
  assign wr_drop = wr_discard | ovf_hit;
  assign wr_pub  = wr_commit & ~wr_drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_err  <= 1'b0;
      ovf_drop <= 1'b0;
    end else if (flush) begin
      ovf_err  <= 1'b0;
      ovf_drop <= 1'b0;
    end else begin
      ovf_drop <= ovf_hit;
      if (wr_discard | ovf_hit)
        ovf_err <= 1'b0;
      else if (wr_en & full)
        ovf_err <= 1'b1;
    end
  end
`else
  assign wr_drop = wr_discard;
  assign wr_pub  = wr_commit & ~wr_discard;
`endif

  always_ff @(posedge CLK) begin
    if (wr_acc & ~wr_drop & ~flush)
      mem[wp[ASIZE-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp       <= '0;
      cwp      <= '0;
      rp       <= '0;
      crp      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_free  <= DEPTH_W;
      rd_avail <= '0;
    end else if (flush) begin
      wp       <= '0;
      cwp      <= '0;
      rp       <= '0;
      crp      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_free  <= DEPTH_W;
      rd_avail <= '0;
    end else begin
      wp <= wr_drop ? cwp : wp_inc;
      if (wr_pub)
        cwp <= wp_inc;

      rp <= rd_rewind ? crp : rp_inc;
      if (rd_commit & ~rd_rewind)
        crp <= rp_inc;

      rd_valid <= rd_acc;
      if (rd_acc)
        rd_data <= mem[rp[ASIZE-1:0]];

      // Counts are pipelined from the current pointer registers.
      wr_free  <= DEPTH_W - used;
      rd_avail <= cwp - rp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_pkt_fifo_tx.sv
`default_nettype none
// ============================================================================
// tb_sync_pkt_fifo_tx : scoreboard bench for sync_pkt_fifo_tx (DEPTH=16).
// Revision 1.0
// ============================================================================
module tb_sync_pkt_fifo_tx;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             flush = 1'b0;
  logic             wr_en = 1'b0;
  logic [DSIZE-1:0] wr_data = '0;
  logic             wr_commit = 1'b0;
  logic             wr_discard = 1'b0;
  logic             rd_en = 1'b0;
  logic             rd_commit = 1'b0;
  logic             rd_rewind = 1'b0;
  logic [DSIZE-1:0] rd_data;
  logic             rd_valid;
  logic             full, almost_full, empty;
  logic [ASIZE:0]   wr_free, rd_avail;
`ifdef SYNC_PKT_FIFO_OVF_DROP_EN
  logic             ovf_drop;
`endif

  int checks = 0;
  int errors = 0;
  logic [DSIZE-1:0] sb [$];

  sync_pkt_fifo_tx #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AF_LEVEL(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit), .wr_discard(wr_discard),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_commit(rd_commit), .rd_rewind(rd_rewind),
    .full(full), .almost_full(almost_full), .empty(empty),
    .wr_free(wr_free),
`ifdef SYNC_PKT_FIFO_OVF_DROP_EN
    .rd_avail(rd_avail), .ovf_drop(ovf_drop)
`else
    .rd_avail(rd_avail)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic write_pkt(input logic [7:0] base, input int n, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      wr_en     = 1'b1;
      wr_data   = 8'(base + i);
      wr_commit = commit_last && (i == n - 1);
      cyc();
    end
    wr_en     = 1'b0;
    wr_commit = 1'b0;
  endtask

  task automatic read_n(input logic [7:0] base, input int n, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      rd_en     = 1'b1;
      rd_commit = commit_last && (i == n - 1);
      sb.push_back(8'(base + i));
      cyc();
    end
    rd_en     = 1'b0;
    rd_commit = 1'b0;
  endtask

  // Monitor: every rd_valid must match the oldest expected word.
  initial begin
    logic [DSIZE-1:0] exp;
    forever begin
      @(negedge CLK);
      if (rd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got data 0x%0h expected no read at %0t", rd_data, $time);
        end else begin
          exp = sb.pop_front();
          chk("rd_data", {24'd0, rd_data}, {24'd0, exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200us");
    $fatal(1);
  end

  initial begin
    idle(3);
    RST = 1'b0;
    cyc();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_wr_free", 32'(wr_free), 16);
    chk("rst_rd_avail", 32'(rd_avail), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);

    // Uncommitted data is invisible; commit publishes it.
    write_pkt(8'h10, 5, 1'b0);
    idle(1);
    chk("t1_empty_precommit", 32'(empty), 1);
    chk("t1_rd_avail_precommit", 32'(rd_avail), 0);
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    chk("t1_empty_postcommit", 32'(empty), 0);
    idle(1);
    chk("t1_rd_avail_postcommit", 32'(rd_avail), 5);
    read_n(8'h10, 5, 1'b1);
    chk("t1_empty_drained", 32'(empty), 1);
    idle(1);
    chk("t1_wr_free", 32'(wr_free), 16);

    // Discard drops the speculative packet; commit includes same-cycle write.
    write_pkt(8'h20, 3, 1'b0);
    wr_discard = 1'b1;
    cyc();
    wr_discard = 1'b0;
    write_pkt(8'hA0, 2, 1'b1);
    idle(1);
    chk("t2_rd_avail", 32'(rd_avail), 2);
    read_n(8'hA0, 2, 1'b1);
    idle(1);
    chk("t2_rd_avail_after", 32'(rd_avail), 0);
    chk("t2_wr_free", 32'(wr_free), 16);

    // Rewind restarts the packet; rd_en in the rewind cycle is ignored.
    write_pkt(8'h30, 6, 1'b1);
    idle(1);
    read_n(8'h30, 4, 1'b0);
    rd_rewind = 1'b1;
    rd_en     = 1'b1;
    cyc();
    rd_rewind = 1'b0;
    rd_en     = 1'b0;
    idle(1);
    chk("t3_rd_avail_rewind", 32'(rd_avail), 6);
    read_n(8'h30, 6, 1'b1);
    idle(1);
    chk("t3_wr_free", 32'(wr_free), 16);

    // Fill; space is held until the read is committed.
    write_pkt(8'h40, 16, 1'b1);
    chk("t4_full", 32'(full), 1);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    cyc();
    wr_en     = 1'b0;
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    idle(1);
    chk("t4_rd_avail", 32'(rd_avail), 16);
    chk("t4_wr_free", 32'(wr_free), 0);
    chk("t4_almost_full", 32'(almost_full), 1);
    read_n(8'h40, 16, 1'b0);
    chk("t4_empty_uncommitted", 32'(empty), 1);
    chk("t4_full_uncommitted", 32'(full), 1);
    rd_commit = 1'b1;
    cyc();
    rd_commit = 1'b0;
    chk("t4_full_released", 32'(full), 0);
    idle(1);
    chk("t4_wr_free_released", 32'(wr_free), 16);
    chk("t4_almost_full_released", 32'(almost_full), 0);

    // Many packets across pointer wrap.
    for (int p = 0; p < 40; p++) begin
      write_pkt(8'(p * 7), 7, 1'b1);
      idle(1);
      chk("t5_rd_avail", 32'(rd_avail), 7);
      chk("t5_wr_free", 32'(wr_free), 9);
      read_n(8'(p * 7), 7, 1'b1);
    end
    idle(1);
    chk("t5_wr_free_end", 32'(wr_free), 16);

    // Flush has priority over everything in its cycle.
    write_pkt(8'h60, 3, 1'b1);
    read_n(8'h60, 1, 1'b0);
    flush     = 1'b1;
    rd_en     = 1'b1;
    wr_en     = 1'b1;
    wr_data   = 8'h99;
    wr_commit = 1'b1;
    cyc();
    flush     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_rd_data", 32'(rd_data), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_full", 32'(full), 0);
    chk("t6_wr_free", 32'(wr_free), 16);
    idle(1);
    chk("t6_rd_avail", 32'(rd_avail), 0);
    write_pkt(8'h70, 2, 1'b1);
    read_n(8'h70, 2, 1'b1);

    idle(3);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
